ran_dispenser: RTL and testbench
================================

Name: ran_dispenser

Overview:
- Round-robin scheduler that shares one 5-bit pseudo-random source among up to 8 game requesters, such as ghost AI units and the music/tone picker.
- Owns the random state register: it seeds it, advances it and hands out one value per grant.
- Uses a req/ack handshake, so each requester gets a distinct draw and no two requesters receive the same value in the same cycle.
- Sits between the game-logic FSMs and the random state. It replaces direct free-running use of the random counter wherever values must not be duplicated.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester draw request. Level signal, held high until the matching ack is seen.
- ack  out  NREQ  one-hot grant pulse, registered, exactly 1 cycle wide.
- rnd_out  out  5  random value for the current grant. Valid in the ack cycle and held until the next grant.
- grant_id  out  3  index of the last granted requester; valid with ack and held afterwards.
- seed_load  in  1  load the random state from seed_val at the next edge.
- seed_val  in  5  seed value.
- busy  out  1  high while the FSM is in HOLD.

Behaviour:
- Reset (rst=1 at an edge; has priority over everything):
  - lfsr=5'h1f, state=ARB, ptr=0.
  - ack=0, rnd_out=0, grant_id=0, busy=0.
  - Any grant in progress is abandoned; a requester still holding req is re-arbitrated normally after reset.
- Next-state function for lfsr, where d=current value and n=next value:
  - n4=d4^d1, n3=d3^d0, n2=d2^n4, n1=d1^n3, n0=d0^n2.
  - n2, n1 and n0 use the already-computed n bits, not the old d bits.
  - Sequence from 5'h1f: 1f, 06, 12, 02, 17, ...
  - 0 maps to 0, so 0 is a lockup value and must never be loaded.
- FSM has two states, ARB and HOLD.
- ARB with no req bit set: ack=0 and the state stays ARB.
- ARB with any req bit set:
  - Winner = first set bit searching upward from ptr, wrapping modulo NREQ.
  - At the edge: ack[winner]=1, rnd_out=lfsr (pre-advance value), grant_id=winner.
  - Also at the edge: ptr=(winner+1) mod NREQ, lfsr advances once, state goes to HOLD.
- HOLD (exactly one cycle):
  - ack returns to 0, busy=1.
  - req is ignored, so the granted requester has time to drop req.
  - Next state is ARB.
- Throughput is at most one grant every 2 cycles. Latency from req sampled high in ARB to ack high is 1 edge.
- seed_load=1 at an edge:
  - lfsr takes seed_val, or 5'h1f if seed_val==0.
  - Load overrides any advance in the same cycle.
  - A grant in the same edge still issues the pre-load lfsr value.
  - The FSM and ptr are unaffected.
- A requester that keeps req high past HOLD is treated as a new request and arbitrated fairly against the others.
- Requests arriving during HOLD wait for the next ARB cycle.

Optional Feature:
- Macro: RAN_FREERUN_EN.
- Defined: lfsr also advances on every edge, in both ARB and HOLD and with or without requests, unless seed_load or rst is active. Drawn values then depend on request timing.
- Undefined: lfsr advances only on a grant, so the sequence of drawn values is deterministic regardless of timing.

Test Plan:
- Build without RAN_FREERUN_EN.
  - Release rst, then hold req=4'b0001 and drop it after ack -> ack=4'b0001 one edge later, rnd_out=5'h1f, grant_id=0. A second draw by requester 0 -> rnd_out=5'h06.
  - After reset, req=4'b1111 held, each bit dropped in the cycle after its ack -> grants in order 0,1,2,3, two cycles apart, with rnd_out=1f,06,12,02. busy=1 in each cycle between grants.
  - seed_load=1 with seed_val=0, then a draw -> rnd_out=5'h1f. seed_load with seed_val=5'h06, then two draws -> rnd_out=06 then 12.
  - Assert rst in HOLD after the first grant, with req=4'b0011 still high -> ack=0, ptr=0. The next grant goes to requester 0 with rnd_out=5'h1f.
  - seed_load=1 with seed_val=5'h02 at the same edge as a grant (lfsr=1f) -> that grant's rnd_out=1f; the next draw gives 02, then 17.
- Build with RAN_FREERUN_EN.
  - req=4'b0110 high from the first edge after reset, each bit dropped after its ack -> requester 1 gets 5'h1f, requester 2 gets 5'h12 two edges later.

Source files
------------

// File: rtl/ran_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : ran_dispenser
// Description : Round-robin dispenser of 5-bit pseudo-random values to up to
//               8 requesters over a req/ack handshake. Owns the random state:
//               seeds it, advances it and hands out one value per grant.
//               Optional macro RAN_FREERUN_EN: when defined the random state
//               advances on every edge instead of only on a grant.
// Revision    : 1.0 - initial release
// ============================================================================
module ran_dispenser #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    output logic [4:0]      rnd_out,
    output logic [2:0]      grant_id,
    input  logic            seed_load,
    input  logic [4:0]      seed_val,
    output logic            busy
);

    localparam logic [4:0] c_LFSR_INIT = 5'h1f;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_lfsr;
    logic [4:0]      w_lfsr_nxt;
    logic [2:0]      r_ptr;
    logic [2*NREQ-1:0] w_req2;
    logic [NREQ-1:0] w_rot;
    logic [2:0]      w_off;
    logic            w_found;
    logic [2:0]      w_winner;
    logic [NREQ-1:0] w_onehot;
    logic            w_grant;
    logic            w_advance;

    // Serial-style step: the low three bits reuse the freshly computed high bits.
    always_comb begin
        w_lfsr_nxt    = '0;
        w_lfsr_nxt[4] = r_lfsr[4] ^ r_lfsr[1];
        w_lfsr_nxt[3] = r_lfsr[3] ^ r_lfsr[0];
        w_lfsr_nxt[2] = r_lfsr[2] ^ w_lfsr_nxt[4];
        w_lfsr_nxt[1] = r_lfsr[1] ^ w_lfsr_nxt[3];
        w_lfsr_nxt[0] = r_lfsr[0] ^ w_lfsr_nxt[2];
    end

    // Rotate requests so bit 0 is the pointer position, then take the lowest set bit.
    assign w_req2 = {req, req};
    assign w_rot  = NREQ'(w_req2 >> r_ptr);

    // Priority search over the rotated view, translated back to a requester index.
    always_comb begin
        w_found  = 1'b0;
        w_off    = '0;
        w_onehot = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = 3'(k);
            end
        end
        w_winner = 3'((int'(r_ptr) + int'(w_off)) % NREQ);
        for (int k = 0; k < NREQ; k++) begin
            w_onehot[k] = (w_winner == 3'(k));
        end
    end

    // Arbitrate only in ARB; HOLD always lasts one cycle and ignores requests.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ARB: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                busy        = 1'b1;
                w_state_nxt = ARB;
            end
            default: w_state_nxt = ARB;
        endcase
    end

`ifdef RAN_FREERUN_EN
    assign w_advance = 1'b1;
`else
    assign w_advance = w_grant;
`endif

    // State register for the arbitration FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant outputs, round-robin pointer and random state; seed load beats advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr   <= c_LFSR_INIT;
            r_ptr    <= '0;
            ack      <= '0;
            rnd_out  <= '0;
            grant_id <= '0;
        end else begin
            ack <= w_grant ? w_onehot : '0;
            if (w_grant) begin
                rnd_out  <= r_lfsr;
                grant_id <= w_winner;
                r_ptr    <= 3'((int'(w_winner) + 1) % NREQ);
            end
            if (seed_load) begin
                r_lfsr <= (seed_val == 5'd0) ? c_LFSR_INIT : seed_val;
            end else if (w_advance) begin
                r_lfsr <= w_lfsr_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ran_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_ran_dispenser
// Description : Self-checking bench for ran_dispenser: directed vector table,
//               hand-written corner sequences and randomized stimulus against
//               a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ran_dispenser;

    localparam int NREQ = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic            seed_load = 1'b0;
    logic [4:0]      seed_val = '0;
    logic [NREQ-1:0] ack;
    logic [4:0]      rnd_out;
    logic [2:0]      grant_id;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    ran_dispenser #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .rnd_out   (rnd_out),
        .grant_id  (grant_id),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [4:0]      m_lfsr = 5'h1f;
    bit              m_hold = 1'b0;
    int              m_ptr  = 0;
    logic [NREQ-1:0] m_ack  = '0;
    logic [4:0]      m_rnd  = '0;
    int              m_gid  = 0;

    function automatic logic [4:0] lfsr_step(input logic [4:0] d);
        logic [4:0] n;
        n[4] = d[4] ^ d[1];
        n[3] = d[3] ^ d[0];
        n[2] = d[2] ^ n[4];
        n[1] = d[1] ^ n[3];
        n[0] = d[0] ^ n[2];
        return n;
    endfunction

    task automatic model_edge();
        bit grant;
        int w;
        if (rst) begin
            m_lfsr = 5'h1f;
            m_hold = 1'b0;
            m_ptr  = 0;
            m_ack  = '0;
            m_rnd  = '0;
            m_gid  = 0;
        end else begin
            grant = !m_hold && (req != '0);
            m_ack = '0;
            if (grant) begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                end
                m_ack[w] = 1'b1;
                m_rnd    = m_lfsr;
                m_gid    = w;
                m_ptr    = (w + 1) % NREQ;
            end
            if (seed_load) begin
                m_lfsr = (seed_val == 5'd0) ? 5'h1f : seed_val;
            end else begin
`ifdef RAN_FREERUN_EN
                m_lfsr = lfsr_step(m_lfsr);
`else
                if (grant) m_lfsr = lfsr_step(m_lfsr);
`endif
            end
            m_hold = grant;
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_ack",  int'(ack),      int'(m_ack));
        check("model_rnd",  int'(rnd_out),  int'(m_rnd));
        check("model_gid",  int'(grant_id), m_gid);
        check("model_busy", int'(busy),     int'(m_hold));
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] req;
        bit         sl;
        logic [4:0] sv;
        logic [3:0] ack;
        logic [4:0] rnd;
        int         gid;
        bit         busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input logic [3:0] q, input bit sl, input logic [4:0] sv,
                       input logic [3:0] a, input logic [4:0] rn, input int g, input bit b);
        vec_t v;
        v.rst = r; v.req = q; v.sl = sl; v.sv = sv;
        v.ack = a; v.rnd = rn; v.gid = g; v.busy = b;
        vecs.push_back(v);
    endtask

    initial begin
        // Single requester: two draws
        add(1, 4'b0000, 0, 5'h00, 4'b0000, 5'h00, 0, 0);
        add(0, 4'b0001, 0, 5'h00, 4'b0001, 5'h1f, 0, 1);
        add(0, 4'b0000, 0, 5'h00, 4'b0000, 5'h1f, 0, 0);
        add(0, 4'b0001, 0, 5'h00, 4'b0001, 5'h06, 0, 1);
        add(0, 4'b0000, 0, 5'h00, 4'b0000, 5'h06, 0, 0);
        // All four requesting, each dropped after its ack
        add(1, 4'b0000, 0, 5'h00, 4'b0000, 5'h00, 0, 0);
        add(0, 4'b1111, 0, 5'h00, 4'b0001, 5'h1f, 0, 1);
        add(0, 4'b1110, 0, 5'h00, 4'b0000, 5'h1f, 0, 0);
        add(0, 4'b1110, 0, 5'h00, 4'b0010, 5'h06, 1, 1);
        add(0, 4'b1100, 0, 5'h00, 4'b0000, 5'h06, 1, 0);
        add(0, 4'b1100, 0, 5'h00, 4'b0100, 5'h12, 2, 1);
        add(0, 4'b1000, 0, 5'h00, 4'b0000, 5'h12, 2, 0);
        add(0, 4'b1000, 0, 5'h00, 4'b1000, 5'h02, 3, 1);
        add(0, 4'b0000, 0, 5'h00, 4'b0000, 5'h02, 3, 0);
        // Seed of zero maps to 1f; seed 06 loaded during HOLD
        add(0, 4'b0000, 1, 5'h00, 4'b0000, 5'h02, 3, 0);
        add(0, 4'b0001, 0, 5'h00, 4'b0001, 5'h1f, 0, 1);
        add(0, 4'b0000, 1, 5'h06, 4'b0000, 5'h1f, 0, 0);
        add(0, 4'b0001, 0, 5'h00, 4'b0001, 5'h06, 0, 1);
        add(0, 4'b0000, 0, 5'h00, 4'b0000, 5'h06, 0, 0);
        add(0, 4'b0001, 0, 5'h00, 4'b0001, 5'h12, 0, 1);
        add(0, 4'b0000, 0, 5'h00, 4'b0000, 5'h12, 0, 0);
        // Reset in HOLD with requests still high
        add(1, 4'b0000, 0, 5'h00, 4'b0000, 5'h00, 0, 0);
        add(0, 4'b0011, 0, 5'h00, 4'b0001, 5'h1f, 0, 1);
        add(1, 4'b0011, 0, 5'h00, 4'b0000, 5'h00, 0, 0);
        add(0, 4'b0011, 0, 5'h00, 4'b0001, 5'h1f, 0, 1);
        add(0, 4'b0010, 0, 5'h00, 4'b0000, 5'h1f, 0, 0);
        add(0, 4'b0010, 0, 5'h00, 4'b0010, 5'h06, 1, 1);
        add(0, 4'b0000, 0, 5'h00, 4'b0000, 5'h06, 1, 0);
        // Seed load on the same edge as a grant
        add(1, 4'b0000, 0, 5'h00, 4'b0000, 5'h00, 0, 0);
        add(0, 4'b0001, 1, 5'h02, 4'b0001, 5'h1f, 0, 1);
        add(0, 4'b0000, 0, 5'h00, 4'b0000, 5'h1f, 0, 0);
        add(0, 4'b0001, 0, 5'h00, 4'b0001, 5'h02, 0, 1);
        add(0, 4'b0000, 0, 5'h00, 4'b0000, 5'h02, 0, 0);
        add(0, 4'b0001, 0, 5'h00, 4'b0001, 5'h17, 0, 1);
        add(0, 4'b0000, 0, 5'h00, 4'b0000, 5'h17, 0, 0);

        #1;
`ifndef RAN_FREERUN_EN
        foreach (vecs[i]) begin
            rst       = vecs[i].rst;
            req       = vecs[i].req;
            seed_load = vecs[i].sl;
            seed_val  = vecs[i].sv;
            step();
            check($sformatf("vec%0d_ack", i),  int'(ack),      int'(vecs[i].ack));
            check($sformatf("vec%0d_rnd", i),  int'(rnd_out),  int'(vecs[i].rnd));
            check($sformatf("vec%0d_gid", i),  int'(grant_id), vecs[i].gid);
            check($sformatf("vec%0d_busy", i), int'(busy),     int'(vecs[i].busy));
        end
`else
        // Free-running state: requester 1 then 2, values 1f then 12
        rst = 1'b1; req = '0; seed_load = 1'b0;
        step();
        rst = 1'b0; req = 4'b0110;
        step();
        check("fr_ack1", int'(ack), 4'b0010);
        check("fr_rnd1", int'(rnd_out), 5'h1f);
        req = 4'b0100;
        step();
        check("fr_hold_ack", int'(ack), 0);
        check("fr_hold_busy", int'(busy), 1);
        step();
        check("fr_ack2", int'(ack), 4'b0100);
        check("fr_rnd2", int'(rnd_out), 5'h12);
        check("fr_gid2", int'(grant_id), 2);
        req = '0;
        step();
`endif

        // Randomized traffic against the model
        rst = 1'b1; req = '0; seed_load = 1'b0; seed_val = '0;
        step();
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 63) == 0);
            seed_load = ($urandom_range(0, 15) == 0);
            seed_val  = 5'($urandom_range(0, 31));
            req       = 4'($urandom_range(0, 15));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
